// File: rtl/dma_copy_engine_pkg.sv
// Shared definitions for the DMA copy engine: register map, CTRL bits,
// FSM state encoding and default bus widths.
package dma_copy_engine_pkg;

    localparam int DEF_AW = 19;
    localparam int DEF_DW = 19;

    // register offsets, decoded from bus_addr[1:0]
    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_SRC  = 2'd1;
    localparam logic [1:0] REG_DST  = 2'd2;
    localparam logic [1:0] REG_LEN  = 2'd3;

    // CTRL bit positions (start on write, busy/done on read)
    localparam int CTRL_START = 0;
    localparam int CTRL_BUSY  = 0;
    localparam int CTRL_DONE  = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_REQ  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_WR_REQ  = 2'd3
    } state_t;

endpackage

// File: rtl/dma_copy_engine_if.sv
// Bus bundles of the copy engine: register access port (engine is the
// responder) and memory request port (engine is the initiator).
interface dma_reg_if
    import dma_copy_engine_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          bus_valid;
    logic          bus_write;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;

    modport master (output bus_valid, bus_write, bus_addr, bus_wdata,
                    input  bus_rdata);
    modport slave  (input  bus_valid, bus_write, bus_addr, bus_wdata,
                    output bus_rdata);
endinterface

interface dma_mem_if
    import dma_copy_engine_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          mem_valid;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport master (output mem_valid, mem_write, mem_addr, mem_wdata,
                    input  mem_rdata, mem_ready);
    modport slave  (input  mem_valid, mem_write, mem_addr, mem_wdata,
                    output mem_rdata, mem_ready);
endinterface

// File: rtl/dma_copy_engine.sv
// Register-programmed word copy engine: reads LEN words starting at SRC
// and writes them to DST, one read/capture/write triple per word.
module dma_copy_engine
    import dma_copy_engine_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic      clk,
    input  logic      rst,
    dma_reg_if.slave  bus,
    dma_mem_if.master mem
);

    state_t        state, state_nxt;
    logic [DW-1:0] src_q, dst_q, len_q, idx_q, data_q;
    logic [DW-1:0] idx_inc;
    logic          done_q;
    logic          idle, reg_wr, start_req, last_word;
    logic          mem_valid_c, mem_write_c;
    logic [1:0]    sel;
    logic          unused_addr_hi;

    assign sel       = bus.bus_addr[1:0];
    assign idle      = (state == ST_IDLE);
    assign reg_wr    = bus.bus_valid & bus.bus_write;
    assign start_req = reg_wr && (sel == REG_CTRL) && bus.bus_wdata[CTRL_START];
    assign idx_inc   = idx_q + {{(DW-1){1'b0}}, 1'b1};
    assign last_word = (idx_inc == len_q);

    // only the low two address bits select a register
    assign unused_addr_hi = ^bus.bus_addr;

    // FSM state register; reset drops any transfer in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // next state and memory request strobes
    always_comb begin
        state_nxt   = state;
        mem_valid_c = 1'b0;
        mem_write_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_req && (len_q != '0)) state_nxt = ST_RD_REQ;
            end
            ST_RD_REQ: begin
                mem_valid_c = 1'b1;
                if (mem.mem_ready) state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                state_nxt = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                mem_valid_c = 1'b1;
                mem_write_c = 1'b1;
                if (mem.mem_ready) state_nxt = last_word ? ST_IDLE : ST_RD_REQ;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // memory port drive; address wraps naturally at AW bits
    assign mem.mem_valid = mem_valid_c;
    assign mem.mem_write = mem_write_c;
    assign mem.mem_addr  = (state == ST_WR_REQ) ? (AW'(dst_q) + AW'(idx_q))
                                                : (AW'(src_q) + AW'(idx_q));
    assign mem.mem_wdata = data_q;

    // register file, word index, data capture and sticky done flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            idx_q  <= '0;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            if (idle && reg_wr) begin
                case (sel)
                    REG_SRC: src_q <= bus.bus_wdata;
                    REG_DST: dst_q <= bus.bus_wdata;
                    REG_LEN: len_q <= bus.bus_wdata;
                    default: ;
                endcase
            end
            if (idle && start_req) begin
                // a zero-length start completes immediately without traffic
                if (len_q == '0) begin
                    done_q <= 1'b1;
                end else begin
                    done_q <= 1'b0;
                    idx_q  <= '0;
                end
            end
            if (state == ST_RD_WAIT) data_q <= mem.mem_rdata;
            if ((state == ST_WR_REQ) && mem.mem_ready) begin
                idx_q <= idx_inc;
                if (last_word) done_q <= 1'b1;
            end
        end
    end

    // register readback, purely combinational on the select bits
    always_comb begin
        bus.bus_rdata = '0;
        case (sel)
            REG_CTRL: begin
                bus.bus_rdata[CTRL_BUSY] = ~idle;
                bus.bus_rdata[CTRL_DONE] = done_q;
            end
            REG_SRC: bus.bus_rdata = src_q;
            REG_DST: bus.bus_rdata = dst_q;
            REG_LEN: bus.bus_rdata = len_q;
            default: bus.bus_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Self-checking bench for dma_copy_engine: directed corner cases plus
// randomized copies with random arbiter stalls, checked against the
// expected read/write address and data sequences.
module tb_dma_copy_engine;
    import dma_copy_engine_pkg::*;

    localparam int AW   = 19;
    localparam int DW   = 19;
    localparam int MASK = (1 << AW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dma_reg_if #(.AW(AW), .DW(DW)) rb ();
    dma_mem_if #(.AW(AW), .DW(DW)) mb ();

    dma_copy_engine #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (rb),
        .mem (mb)
    );

    // memory model: source contents preloaded by the stimulus, DUT traffic logged
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q = '0;
    int            rlog_a[$];
    int            wlog_a[$];
    int            wlog_d[$];
    int            valid_cnt = 0;

    logic fix_rdy  = 1'b1;
    logic rand_rdy = 1'b0;
    logic rnd_bit  = 1'b1;

    assign mb.mem_ready = rand_rdy ? rnd_bit : fix_rdy;
    assign mb.mem_rdata = rdata_q;

    // random arbiter grant, roughly 75% granted
    always @(negedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);

    // respond to accepted requests and record them
    always @(posedge clk) begin
        if (mb.mem_valid) valid_cnt <= valid_cnt + 1;
        if (mb.mem_valid && mb.mem_ready) begin
            if (mb.mem_write) begin
                wlog_a.push_back(int'(mb.mem_addr));
                wlog_d.push_back(int'(mb.mem_wdata));
            end else begin
                rlog_a.push_back(int'(mb.mem_addr));
                rdata_q <= ram[mb.mem_addr];
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;
    int exp_data[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        rb.bus_valid = 1'b1;
        rb.bus_write = 1'b1;
        rb.bus_addr  = AW'(a);
        rb.bus_wdata = d;
        @(negedge clk);
        rb.bus_valid = 1'b0;
        rb.bus_write = 1'b0;
    endtask

    task automatic reg_rd(input logic [1:0] a, output logic [DW-1:0] d);
        rb.bus_addr = AW'(a);
        #1 d = rb.bus_rdata;
    endtask

    // count cycles until CTRL.done, continuing from an existing count
    task automatic wait_done(inout int cyc);
        logic [DW-1:0] v;
        v = '0;
        while (!v[CTRL_DONE] && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            reg_rd(REG_CTRL, v);
        end
        if (!v[CTRL_DONE]) chk("done_timeout", 32'(cyc), 32'd1000 + 32'd1);
    endtask

    // preload len words of random (or counting) data at src and remember them
    task automatic fill(input int src, input int len, input bit counting);
        exp_data.delete();
        for (int i = 0; i < len; i++) begin
            int d;
            d = counting ? (i + 1) : int'($urandom_range(0, MASK));
            ram[(src + i) & MASK] = DW'(d);
            exp_data.push_back(d);
        end
    endtask

    task automatic start_copy(input int src, input int dst, input int len);
        reg_wr(REG_SRC, DW'(src));
        reg_wr(REG_DST, DW'(dst));
        reg_wr(REG_LEN, DW'(len));
        reg_wr(REG_CTRL, DW'(1));
    endtask

    // compare logged traffic since the given bases with the expected copy
    task automatic check_copy(input string tag, input int src, input int dst,
                              input int len, input int rbase, input int wbase);
        chk({tag, "_nrd"}, 32'(rlog_a.size() - rbase), 32'(len));
        chk({tag, "_nwr"}, 32'(wlog_a.size() - wbase), 32'(len));
        for (int i = 0; i < len; i++) begin
            if (rbase + i < rlog_a.size())
                chk({tag, "_rd_addr"}, 32'(rlog_a[rbase+i]), 32'((src + i) & MASK));
            if (wbase + i < wlog_a.size()) begin
                chk({tag, "_wr_addr"}, 32'(wlog_a[wbase+i]), 32'((dst + i) & MASK));
                chk({tag, "_wr_data"}, 32'(wlog_d[wbase+i]), 32'(exp_data[i]));
            end
        end
    endtask

    initial begin
        logic [DW-1:0] v;
        int cyc, rb0, wb0, vc0;

        rb.bus_valid = 1'b0;
        rb.bus_write = 1'b0;
        rb.bus_addr  = '0;
        rb.bus_wdata = '0;

        // reset state
        rst = 1'b1;
        #12;
        chk("rst_mem_valid", 32'(mb.mem_valid), 32'd0);
        chk("rst_mem_addr",  32'(mb.mem_addr),  32'd0);
        chk("rst_mem_wdata", 32'(mb.mem_wdata), 32'd0);
        for (int r = 0; r < 4; r++) begin
            reg_rd(2'(r), v);
            chk("rst_reg", 32'(v), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // zero-length start: done next cycle, no memory traffic
        vc0 = valid_cnt;
        reg_wr(REG_LEN, '0);
        reg_wr(REG_CTRL, DW'(1));
        reg_rd(REG_CTRL, v);
        chk("len0_ctrl", 32'(v), 32'h2);
        repeat (5) @(negedge clk);
        chk("len0_no_valid", 32'(valid_cnt - vc0), 32'd0);

        // basic 4-word copy, 12 cycles with grant tied high
        fill(32'h100, 4, 1'b1);
        rb0 = rlog_a.size(); wb0 = wlog_a.size();
        start_copy(32'h100, 32'h200, 4);
        reg_rd(REG_CTRL, v);
        chk("basic_busy", 32'(v), 32'h1);
        cyc = 0;
        wait_done(cyc);
        chk("basic_cycles", 32'(cyc), 32'd12);
        check_copy("basic", 32'h100, 32'h200, 4, rb0, wb0);

        // grant held low for 5 cycles on the first read
        fill(32'h300, 4, 1'b0);
        rb0 = rlog_a.size(); wb0 = wlog_a.size();
        reg_wr(REG_SRC, DW'(32'h300));
        reg_wr(REG_DST, DW'(32'h380));
        reg_wr(REG_LEN, DW'(4));
        fix_rdy = 1'b0;
        reg_wr(REG_CTRL, DW'(1));
        cyc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cyc++;
            chk("stall_valid", 32'(mb.mem_valid), 32'd1);
            chk("stall_addr",  32'(mb.mem_addr),  32'h300);
            chk("stall_write", 32'(mb.mem_write), 32'd0);
        end
        fix_rdy = 1'b1;
        wait_done(cyc);
        chk("stall_cycles", 32'(cyc), 32'd17);
        check_copy("stall", 32'h300, 32'h380, 4, rb0, wb0);

        // source address wraps past the top of the space
        fill(32'h7FFFE, 3, 1'b0);
        rb0 = rlog_a.size(); wb0 = wlog_a.size();
        start_copy(32'h7FFFE, 32'h400, 3);
        cyc = 0;
        wait_done(cyc);
        chk("wrap_cycles", 32'(cyc), 32'd9);
        check_copy("wrap", 32'h7FFFE, 32'h400, 3, rb0, wb0);

        // register writes and start while busy are ignored
        fill(32'h100, 4, 1'b1);
        rb0 = rlog_a.size(); wb0 = wlog_a.size();
        start_copy(32'h100, 32'h600, 4);
        reg_wr(REG_SRC, DW'(32'h500));
        reg_wr(REG_CTRL, DW'(1));
        reg_rd(REG_CTRL, v);
        chk("busy_ctrl", 32'(v), 32'h1);
        reg_rd(REG_SRC, v);
        chk("busy_src", 32'(v), 32'h100);
        cyc = 4;
        wait_done(cyc);
        repeat (6) @(negedge clk);
        check_copy("busy", 32'h100, 32'h600, 4, rb0, wb0);

        // reset during the write of word 2 of 4
        start_copy(32'h100, 32'h700, 4);
        repeat (8) @(negedge clk);
        chk("mid_write", 32'(mb.mem_write), 32'd1);
        chk("mid_addr",  32'(mb.mem_addr),  32'h702);
        rst = 1'b1;
        #1;
        chk("abort_valid", 32'(mb.mem_valid), 32'd0);
        vc0 = valid_cnt;
        for (int r = 0; r < 4; r++) begin
            reg_rd(2'(r), v);
            chk("abort_reg", 32'(v), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_no_resume", 32'(valid_cnt - vc0), 32'd0);

        // randomized copies with random grant stalls
        rand_rdy = 1'b1;
        for (int t = 0; t < 6; t++) begin
            int src, dst, len;
            src = int'($urandom_range(0, MASK));
            dst = src ^ 32'h40000;
            len = int'($urandom_range(1, 8));
            fill(src, len, 1'b0);
            rb0 = rlog_a.size(); wb0 = wlog_a.size();
            start_copy(src, dst, len);
            cyc = 0;
            wait_done(cyc);
            if (cyc < 3 * len) chk("rand_min_cycles", 32'(cyc), 32'(3 * len));
            check_copy("rand", src, dst, len, rb0, wb0);
        end
        rand_rdy = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
